// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: horizontal/vertical counters with registered sync, blanking,
// line/frame pulses and a wrapping frame counter. Every output comes straight from a flop.
module vga_sync_gen #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33
) (
  input  logic       clk_25,
  input  logic       reset,
  input  logic       en,
  output logic [9:0] h_count,
  output logic [9:0] v_count,
  output logic       bright,
  output logic       hsync,
  output logic       vsync,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  localparam int unsigned HTotal = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned VTotal = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] HLast     = 10'(HTotal - 1);
  localparam logic [9:0] VLast     = 10'(VTotal - 1);
  localparam logic [9:0] HVis      = 10'(H_VISIBLE);
  localparam logic [9:0] VVis      = 10'(V_VISIBLE);
  localparam logic [9:0] HSyncBeg  = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HSyncEnd  = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VSyncBeg  = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VSyncEnd  = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [9:0] h_q, h_d;
  logic [9:0] v_q, v_d;
  logic       bright_q, bright_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       line_start_q, line_start_d;
  logic       frame_start_q, frame_start_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;

  // Decoded outputs are derived from the next-state counts so they line up with the counters.
  always_comb begin
    h_d           = h_q;
    v_d           = v_q;
    bright_d      = bright_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    line_start_d  = line_start_q;
    frame_start_d = frame_start_q;
    frame_cnt_d   = frame_cnt_q;
    if (en) begin
      if (h_q == HLast) begin
        h_d = '0;
        v_d = (v_q == VLast) ? '0 : v_q + 10'd1;
      end else begin
        h_d = h_q + 10'd1;
      end
      bright_d      = (h_d < HVis) && (v_d < VVis);
      hsync_d       = !((h_d >= HSyncBeg) && (h_d < HSyncEnd));
      vsync_d       = !((v_d >= VSyncBeg) && (v_d < VSyncEnd));
      line_start_d  = (h_d == '0);
      frame_start_d = (h_d == '0) && (v_d == '0);
      // Only a real move into (0,0) counts; a pulse held through a stall never re-triggers.
      if (frame_start_d) begin
        frame_cnt_d = frame_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk_25 or posedge reset) begin
    if (reset) begin
      h_q           <= HLast;
      v_q           <= VLast;
      bright_q      <= 1'b0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      h_q           <= h_d;
      v_q           <= v_d;
      bright_q      <= bright_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign h_count     = h_q;
  assign v_count     = v_q;
  assign bright      = bright_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign frame_count = frame_cnt_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen with a shrunken raster; expected outputs come from the number of
// enabled clocks since reset release, converted to a raster position with plain arithmetic.
module tb_vga_sync_gen;

  localparam int HV = 8;
  localparam int HF = 2;
  localparam int HS = 3;
  localparam int HB = 2;
  localparam int VV = 4;
  localparam int VF = 1;
  localparam int VS = 2;
  localparam int VB = 2;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FT = HT * VT;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic [9:0] h_count;
  logic [9:0] v_count;
  logic       bright;
  logic       hsync;
  logic       vsync;
  logic       line_start;
  logic       frame_start;
  logic [7:0] frame_count;

  int     checks = 0;
  int     errors = 0;
  longint p = 0;  // enabled clocks since reset release

  vga_sync_gen #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
  ) dut (
    .clk_25     (clk),
    .reset      (reset),
    .en         (en),
    .h_count    (h_count),
    .v_count    (v_count),
    .bright     (bright),
    .hsync      (hsync),
    .vsync      (vsync),
    .line_start (line_start),
    .frame_start(frame_start),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int exp_h(input longint pp);
    return int'(((pp + FT - 1) % FT) % HT);
  endfunction

  function automatic int exp_v(input longint pp);
    return int'(((pp + FT - 1) % FT) / HT);
  endfunction

  function automatic int exp_fc(input longint pp);
    return int'(((pp + FT - 1) / FT) % 256);
  endfunction

  function automatic logic [32:0] exp_vec(input longint pp);
    int  eh, ev;
    logic b, hs, vs, ls, fs;
    eh = exp_h(pp);
    ev = exp_v(pp);
    b  = (eh < HV) && (ev < VV);
    hs = !((eh >= HV + HF) && (eh < HV + HF + HS));
    vs = !((ev >= VV + VF) && (ev < VV + VF + VS));
    ls = (eh == 0);
    fs = (eh == 0) && (ev == 0);
    return {10'(eh), 10'(ev), b, hs, vs, ls, fs, 8'(exp_fc(pp))};
  endfunction

  function automatic logic [32:0] dut_vec();
    return {h_count, v_count, bright, hsync, vsync, line_start, frame_start, frame_count};
  endfunction

  // One clock: drive en, advance the model on the edge, compare at the falling edge.
  task automatic tick(input logic e);
    en = e;
    @(posedge clk);
    if (!reset && e) p++;
    @(negedge clk);
    check_val("model", 64'(dut_vec()), 64'(exp_vec(p)));
  endtask

  task automatic run_to(input int th, input int tv, input string tag);
    int n;
    n = 0;
    while (!(int'(h_count) == th && int'(v_count) == tv) && n < 2 * FT) begin
      tick(1'b1);
      n++;
    end
    check_val({tag, "_reached"}, 64'(n < 2 * FT), 64'(1));
  endtask

  task automatic check_reset_vals(input string tag);
    check_val({tag, "_h"}, 64'(h_count), 64'(HT - 1));
    check_val({tag, "_v"}, 64'(v_count), 64'(VT - 1));
    check_val({tag, "_flags"}, 64'({bright, hsync, vsync, line_start, frame_start}),
              64'(5'b01100));
    check_val({tag, "_fc"}, 64'(frame_count), 64'(0));
  endtask

  task automatic check_first_cycle(input string tag);
    check_val({tag, "_h"}, 64'(h_count), 64'(0));
    check_val({tag, "_v"}, 64'(v_count), 64'(0));
    check_val({tag, "_bright"}, 64'(bright), 64'(1));
    check_val({tag, "_ls"}, 64'(line_start), 64'(1));
    check_val({tag, "_fs"}, 64'(frame_start), 64'(1));
    check_val({tag, "_fc"}, 64'(frame_count), 64'(1));
  endtask

  initial begin
    int  hs_run, vs_run, bcnt, last_fs, cyc, fc_hold;
    logic prev_hs, prev_vs, have_fs;

    reset = 1'b1;
    en    = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    @(posedge clk);
    @(negedge clk);
    check_reset_vals("reset_hold");

    // Release into the first frame.
    reset = 1'b0;
    p     = 0;
    tick(1'b1);
    check_first_cycle("release");
    for (int i = 2; i <= HV + 1; i++) begin
      tick(1'b1);
      if (i == HV) begin
        check_val("last_visible_h", 64'(h_count), 64'(HV - 1));
        check_val("last_visible_bright", 64'(bright), 64'(1));
      end
      if (i == HV + 1) begin
        check_val("first_blank_h", 64'(h_count), 64'(HV));
        check_val("first_blank_bright", 64'(bright), 64'(0));
      end
    end

    // Sync widths, frame period and visible pixels over two full frames.
    prev_hs = hsync;
    prev_vs = vsync;
    hs_run  = 0;
    vs_run  = 0;
    bcnt    = 0;
    last_fs = 0;
    have_fs = 1'b0;
    for (cyc = 1; cyc <= 2 * FT + 2; cyc++) begin
      tick(1'b1);
      if (prev_hs && !hsync) begin
        check_val("hsync_start_h", 64'(h_count), 64'(HV + HF));
        hs_run = 0;
      end
      if (!hsync) hs_run++;
      if (!prev_hs && hsync) check_val("hsync_width", 64'(hs_run), 64'(HS));
      if (prev_vs && !vsync) begin
        check_val("vsync_start_v", 64'(v_count), 64'(VV + VF));
        check_val("vsync_start_h", 64'(h_count), 64'(0));
        vs_run = 0;
      end
      if (!vsync) vs_run++;
      if (!prev_vs && vsync) check_val("vsync_width", 64'(vs_run), 64'(VS * HT));
      if (frame_start) begin
        if (have_fs) begin
          check_val("frame_period", 64'(cyc - last_fs), 64'(FT));
          check_val("bright_per_frame", 64'(bcnt), 64'(HV * VV));
        end
        have_fs = 1'b1;
        last_fs = cyc;
        bcnt    = 0;
      end
      if (bright) bcnt++;
      prev_hs = hsync;
      prev_vs = vsync;
    end

    // Frame wrap and line wrap.
    run_to(HT - 1, VT - 1, "frame_end");
    tick(1'b1);
    check_val("fwrap_hv", 64'({h_count, v_count}), 64'(0));
    check_val("fwrap_fs", 64'(frame_start), 64'(1));
    run_to(HT - 1, 2, "line_end");
    tick(1'b1);
    check_val("lwrap_h", 64'(h_count), 64'(0));
    check_val("lwrap_v", 64'(v_count), 64'(3));
    check_val("lwrap_pulses", 64'({line_start, frame_start}), 64'(2'b10));

    // Stall right on (0,0): pulses and frame count must hold, no second increment.
    run_to(0, 0, "stall_origin");
    fc_hold = exp_fc(p);
    repeat (5) begin
      tick(1'b0);
      check_val("stall_h", 64'(h_count), 64'(0));
      check_val("stall_fs", 64'(frame_start), 64'(1));
      check_val("stall_fc", 64'(frame_count), 64'(fc_hold));
    end
    tick(1'b1);
    check_val("resume_h", 64'(h_count), 64'(1));
    check_val("resume_fs", 64'(frame_start), 64'(0));
    check_val("resume_fc", 64'(frame_count), 64'(fc_hold));

    // Random enable pattern against the model.
    repeat (2000) tick(1'($urandom_range(0, 3) != 0));

    // Asynchronous reset between edges, mid-line and mid-frame.
    run_to(5, 2, "async_pos");
    #2 reset = 1'b1;
    #1 check_reset_vals("async_reset");
    @(negedge clk);
    check_reset_vals("async_reset_hold");
    reset = 1'b0;
    p     = 0;
    tick(1'b1);
    check_first_cycle("rerelease");

    // Frame counter wraps 255 -> 0 after 256 frames.
    repeat (254 * FT) tick(1'b1);
    check_val("fc_255", 64'(frame_count), 64'(255));
    repeat (FT) tick(1'b1);
    check_val("fc_wrap", 64'(frame_count), 64'(0));
    check_val("fc_wrap_fs", 64'(frame_start), 64'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
